// File: rtl/instruction_loader.sv
// Program-image loader: assembles big-endian 32-bit words from a byte stream and
// writes them to instruction memory from word 0 upward, holding the CPU frozen meanwhile.
module instruction_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   wordCount,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  memWrite,
    output logic [31:0]           memAddress,
    output logic [31:0]           memData,
    output logic                  cpuFreeze,
    output logic                  cpuReset,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  state_s;
    logic [ADDR_WIDTH:0]     count_r;
    logic [ADDR_WIDTH-1:0]   word_idx_r;
    logic [1:0]              byte_idx_r;
    logic [23:0]             asm_r;
    logic [31:0]             mem_address_r;
    logic [31:0]             mem_data_r;
    logic                    byte_ready_r;
    logic                    mem_write_r;
    logic                    cpu_freeze_r;
    logic                    cpu_reset_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    start_go_s;
    logic                    last_word_s;
    logic [ADDR_WIDTH:0]     clamped_count_s;

    assign start_go_s      = start && (wordCount != CNT_ZERO);
    assign clamped_count_s = (wordCount > MAX_WORDS) ? MAX_WORDS : wordCount;
    assign last_word_s     = ({1'b0, word_idx_r} == (count_r - CNT_ONE));

    // Next-state decode for the load session sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_go_s) state_s = COLLECT;
                else            state_s = IDLE;
            end
            COLLECT: begin
                if (byteValid && (byte_idx_r == 2'd3)) state_s = WRITE;
                else                                   state_s = COLLECT;
            end
            WRITE: begin
                if (last_word_s) state_s = RELEASE;
                else             state_s = COLLECT;
            end
            RELEASE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Counters, word assembly and the registered write address/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r       <= CNT_ZERO;
            word_idx_r    <= IDX_ZERO;
            byte_idx_r    <= 2'd0;
            asm_r         <= 24'h000000;
            mem_address_r <= 32'h0000_0000;
            mem_data_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_go_s) begin
                        count_r    <= clamped_count_s;
                        word_idx_r <= IDX_ZERO;
                        byte_idx_r <= 2'd0;
                    end
                end
                COLLECT: begin
                    if (byteValid) begin
                        asm_r      <= {asm_r[15:0], byteIn};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        // Fourth byte completes the word; address/data change only here.
                        if (byte_idx_r == 2'd3) begin
                            mem_data_r    <= {asm_r, byteIn};
                            mem_address_r <= {{(30-ADDR_WIDTH){1'b0}}, word_idx_r, 2'b00};
                        end
                    end
                end
                WRITE:   word_idx_r <= word_idx_r + IDX_ONE;
                default: ;
            endcase
        end
    end

    // Outputs registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_ready_r <= 1'b0;
            mem_write_r  <= 1'b0;
            cpu_freeze_r <= 1'b0;
            cpu_reset_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            byte_ready_r <= (state_s == COLLECT);
            mem_write_r  <= (state_s == WRITE);
            cpu_freeze_r <= (state_s != IDLE);
            cpu_reset_r  <= (state_s == RELEASE);
            busy_r       <= (state_s != IDLE);
            done_r       <= (state_s == RELEASE);
        end
    end

    assign byteReady  = byte_ready_r;
    assign memWrite   = mem_write_r;
    assign memAddress = mem_address_r;
    assign memData    = mem_data_r;
    assign cpuFreeze  = cpu_freeze_r;
    assign cpuReset   = cpu_reset_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table-driven load sessions with random
// bytes and idle gaps, compared against a word-list model, plus reset/fixed-word sequences.
module tb_instruction_loader;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset, start, byteValid;
    logic [AW:0] wordCount;
    logic [7:0]  byteIn;
    logic        byteReady, memWrite, cpuFreeze, cpuReset, busy, done;
    logic [31:0] memAddress, memData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .wordCount(wordCount),
        .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
        .memWrite(memWrite), .memAddress(memAddress), .memData(memData),
        .cpuFreeze(cpuFreeze), .cpuReset(cpuReset), .busy(busy), .done(done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records writes and pulses, counts protocol-rule violations.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cnt = 0, crst_cnt = 0, busy_cnt = 0, inv_err = 0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clk) begin
        if (memWrite === 1'b1) begin
            wr_addr_q.push_back(memAddress);
            wr_data_q.push_back(memData);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
        if (cpuReset === 1'b1) crst_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (memWrite && (byteReady || !cpuFreeze || !busy)) inv_err++;
        if (done !== cpuReset) inv_err++;
        if (cpuFreeze !== busy) inv_err++;
        if (!busy && (byteReady || memWrite || done)) inv_err++;
        if (memAddress[1:0] !== 2'b00) inv_err++;
        if (!memWrite && !reset && (memAddress !== prev_addr)) inv_err++;
        prev_addr = memAddress;
    end

    typedef struct {
        int          wc;
        int          gap;
        bit          poke;
        int          exp_writes;
        logic [31:0] exp_last;
    } vec_t;

    logic [7:0] bytes_q[$];
    logic [7:0] fixed_q[$];
    int         acc_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Offer bytes_q[0..nbytes-1] with random idle gaps; optionally pulse start mid-session.
    task automatic feed(input int nbytes, input int gap, input bit poke, output bit ok);
        int  sent   = 0;
        int  budget = nbytes * 20 + 50;
        logic rdy, v;
        acc_q.delete();
        while (sent < nbytes && budget > 0) begin
            byteValid = ($urandom_range(99) >= gap);
            byteIn    = bytes_q[sent];
            if (poke) begin
                start     = ($urandom_range(3) == 0);
                wordCount = 9'($urandom_range(511));
            end
            rdy = byteReady;
            v   = byteValid;
            @(posedge clk); #1;
            if (v && rdy) begin
                sent++;
                if (sent % 4 == 0) acc_q.push_back(cyc);
            end
            budget--;
        end
        byteValid = 1'b0;
        start     = 1'b0;
        ok        = (sent == nbytes);
    endtask

    task automatic run_session(input vec_t v, input string tag);
        int  n = (v.wc > DEPTH) ? DEPTH : v.wc;
        int  wbase = wr_addr_q.size();
        int  dbase = done_cnt, cbase = crst_cnt, bbase = busy_cnt, ibase = inv_err;
        int  got;
        bit  ok, seen = 1'b0;
        logic [31:0] w;
        bytes_q.delete();
        for (int i = 0; i < 4 * n; i++)
            bytes_q.push_back((fixed_q.size() == 4 * n) ? fixed_q[i] : 8'($urandom_range(255)));
        start = 1'b1; wordCount = 9'(v.wc);
        @(posedge clk); #1;
        start = 1'b0;
        if (n > 0) begin
            feed(4 * n, v.gap, v.poke, ok);
            chk({tag, "_feed"}, 32'(ok), 32'd1);
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk({tag, "_done_seen"}, 32'(seen), 32'd1);
            @(posedge clk); #1;
        end else begin
            repeat (6) @(posedge clk);
            #1;
        end
        got = wr_addr_q.size() - wbase;
        chk({tag, "_writes"}, got, v.exp_writes);
        chk({tag, "_model_writes"}, got, n);
        for (int i = 0; i < n && i < got; i++) begin
            w = {bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]};
            chk($sformatf("%s_addr[%0d]", tag, i), wr_addr_q[wbase+i], 32'(4 * i));
            chk($sformatf("%s_data[%0d]", tag, i), wr_data_q[wbase+i], w);
            if (i < acc_q.size())
                chk($sformatf("%s_latency[%0d]", tag, i), wr_cyc_q[wbase+i], acc_q[i]);
        end
        if (n > 0 && got > 0) chk({tag, "_last_addr"}, wr_addr_q[wr_addr_q.size()-1], v.exp_last);
        chk({tag, "_done_cnt"}, done_cnt - dbase, (n > 0) ? 1 : 0);
        chk({tag, "_cpureset_cnt"}, crst_cnt - cbase, (n > 0) ? 1 : 0);
        if (v.gap == 0) chk({tag, "_busy_cycles"}, busy_cnt - bbase, (n > 0) ? 5 * n + 1 : 0);
        chk({tag, "_rules"}, inv_err - ibase, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int   wbase, dbase, cbase;
        bit   ok;
        logic [31:0] w0;
        vecs[0] = '{1,   0,  1'b0, 1,   32'h0000_0000};
        vecs[1] = '{3,   40, 1'b0, 3,   32'h0000_0008};
        vecs[2] = '{2,   30, 1'b1, 2,   32'h0000_0004};
        vecs[3] = '{0,   0,  1'b0, 0,   32'h0000_0000};
        vecs[4] = '{256, 0,  1'b0, 256, 32'h0000_03FC};
        vecs[5] = '{300, 10, 1'b0, 256, 32'h0000_03FC};
        vecs[6] = '{511, 0,  1'b1, 256, 32'h0000_03FC};
        vecs[7] = '{5,   50, 1'b1, 5,   32'h0000_0010};

        reset = 1'b1; start = 1'b0; wordCount = 9'd0; byteIn = 8'd0; byteValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", 32'({byteReady, memWrite, cpuFreeze, cpuReset, busy, done}), 32'd0);
        chk("reset_addr", memAddress, 32'h0);
        chk("reset_data", memData, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        fixed_q = '{8'h20, 8'h08, 8'h00, 8'h05};
        run_session(vecs[0], "single_fixed");
        fixed_q.delete();
        chk("single_fixed_word", wr_data_q[wr_data_q.size()-1], 32'h2008_0005);

        // Sessions run back to back: each start lands in the first IDLE cycle after RELEASE.
        for (int i = 0; i < 8; i++) run_session(vecs[i], $sformatf("vec%0d", i));

        bytes_q.delete();
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom_range(255)));
        w0 = {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]};
        wbase = wr_addr_q.size(); dbase = done_cnt; cbase = crst_cnt;
        start = 1'b1; wordCount = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        feed(6, 20, 1'b0, ok);
        chk("midrst_feed", 32'(ok), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_flags", 32'({byteReady, memWrite, cpuFreeze, cpuReset, busy, done}), 32'd0);
        chk("midrst_addr", memAddress, 32'h0);
        chk("midrst_data", memData, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("midrst_writes", wr_addr_q.size() - wbase, 1);
        if (wr_data_q.size() > wbase) chk("midrst_word0", wr_data_q[wbase], w0);
        chk("midrst_no_done", done_cnt - dbase, 0);
        chk("midrst_no_cpureset", crst_cnt - cbase, 0);
        @(posedge clk); #1;
        run_session(vecs[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
